// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a length/data/checksum byte stream into
// little-endian instruction words and writes them into the core's instruction RAM.
module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_COLLECT,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

    state_t              state_q;
    logic [1:0]          byte_idx_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [ADDR_W-1:0]   last_idx_q;
    logic [7:0]          csum_q;
    logic                s_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                core_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic                len_too_big;
    logic [8:0]          len_minus_one;
    logic [ADDR_W-1:0]   last_from_len;
    logic [23:0]         partial_w;

    assign accept        = s_valid && s_ready_q;
    assign len_too_big   = ({1'b0, s_data} > DEPTH_9);
    assign len_minus_one = {1'b0, s_data} - 9'd1;
    // A length byte of zero stands for a full-depth load.
    assign last_from_len = (s_data == 8'd0) ? ADDR_W'(DEPTH - 1) : ADDR_W'(len_minus_one);

    // Lower three bytes of the word in flight; the top byte is taken straight
    // from the bus on the final accept so the word is ready one cycle earlier.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_q <= 8'd0;
                end else if (state_q == S_COLLECT && accept && byte_idx_q == 2'(gi)) begin
                    lane_q <= s_data;
                end
            end
            assign partial_w[8*gi +: 8] = lane_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= 2'd0;
            word_idx_q  <= '0;
            last_idx_q  <= '0;
            csum_q      <= 8'd0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q    <= S_LEN;
                        busy_q     <= 1'b1;
                        s_ready_q  <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        core_rst_q <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (len_too_big) begin
                            state_q    <= S_ERROR;
                            s_ready_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            core_rst_q <= 1'b1;
                        end else begin
                            state_q    <= S_COLLECT;
                            last_idx_q <= last_from_len;
                            csum_q     <= s_data;
                            word_idx_q <= '0;
                            byte_idx_q <= 2'd0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        csum_q     <= csum_q ^ s_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_q     <= S_WRITE;
                            s_ready_q   <= 1'b0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= word_idx_q;
                            mem_wdata_q <= {s_data, partial_w};
                        end
                    end
                end
                S_WRITE: begin
                    s_ready_q <= 1'b1;
                    if (word_idx_q == last_idx_q) begin
                        state_q <= S_CHECK;
                    end else begin
                        word_idx_q <= word_idx_q + 1'b1;
                        state_q    <= S_COLLECT;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b0;
                        if (s_data == csum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q    <= S_ERROR;
                            err_q      <= 1'b1;
                            core_rst_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a cycle-exact vector table for one frame, then
// frame-level sequences for error, full-depth, gapped and reset corner cases.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader #(.ADDR_W(5), .DEPTH(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        ready;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        core_rst;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int ready_in_write = 0;

    logic [7:0]  frame_q[$];
    logic [4:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [4:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    vec_t        tbl[14];

    localparam logic [42:0] RESET_OUTS = {1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    function automatic vec_t mk(logic st, logic v, logic [7:0] d, logic rdy, logic we,
                                logic [4:0] a, logic [31:0] wd, logic cr, logic b,
                                logic dn, logic e);
        vec_t r;
        r.start = st; r.valid = v; r.data = d; r.ready = rdy; r.we = we; r.addr = a;
        r.wdata = wd; r.core_rst = cr; r.busy = b; r.done = dn; r.err = e;
        return r;
    endfunction

    function automatic logic [42:0] outs();
        return {s_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, err};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // One line per RAM write; also flags any write cycle with s_ready high.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            if (s_ready) ready_in_write++;
            $display("write addr=%0d data=%08h", mem_addr, mem_wdata);
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(logic [7:0] b, int gapmax);
        int t;
        if (gapmax > 0) begin
            int g;
            g = $urandom_range(0, gapmax);
            repeat (g) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom_range(0, 255));
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte timeout: s_ready got 0 expected 1");
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(int gapmax);
        foreach (frame_q[i]) send_byte(frame_q[i], gapmax);
    endtask

    task automatic frame1(logic [7:0] csum);
        frame_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, csum};
    endtask

    // Reference writes derived directly from the frame bytes.
    task automatic build_exp();
        int n;
        exp_addr_q.delete();
        exp_data_q.delete();
        n = (frame_q[0] == 8'd0) ? 32 : int'(frame_q[0]);
        for (int w = 0; w < n; w++) begin
            exp_addr_q.push_back(5'(w));
            exp_data_q.push_back({frame_q[4*w+4], frame_q[4*w+3], frame_q[4*w+2], frame_q[4*w+1]});
        end
    endtask

    task automatic check_writes(string name);
        chk({name, " write count"}, 64'(wr_addr_q.size()), 64'(exp_addr_q.size()));
        for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++) begin
            chk($sformatf("%s addr[%0d]", name, i), 64'(wr_addr_q[i]), 64'(exp_addr_q[i]));
            chk($sformatf("%s data[%0d]", name, i), 64'(wr_data_q[i]), 64'(exp_data_q[i]));
        end
    endtask

    task automatic check_status(string name, logic dn, logic e, logic cr);
        chk({name, " done/err/core_rst/busy/ready"}, 64'({done, err, core_rst, busy, s_ready}),
            64'({dn, e, cr, 1'b0, 1'b0}));
    endtask

    initial begin
        logic [7:0] x;
        rst = 1'b1; start = 1'b1; s_valid = 1'b0; s_data = 8'd0;
        #1;
        chk("reset outputs", 64'(outs()), 64'(RESET_OUTS));
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start with rst ignored", 64'(outs()), 64'(RESET_OUTS));

        // Cycle-exact walk through the two-word frame, continuous valid.
        tbl[0]  = mk(1, 0, 8'h00, 1, 0, 0, 32'h0,        1, 1, 0, 0);
        tbl[1]  = mk(0, 1, 8'h02, 1, 0, 0, 32'h0,        1, 1, 0, 0);
        tbl[2]  = mk(0, 1, 8'h13, 1, 0, 0, 32'h0,        1, 1, 0, 0);
        tbl[3]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 1, 0, 0);
        tbl[4]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 1, 0, 0);
        tbl[5]  = mk(0, 1, 8'h00, 0, 1, 0, 32'h13,       1, 1, 0, 0);
        tbl[6]  = mk(0, 1, 8'h93, 1, 0, 0, 32'h13,       1, 1, 0, 0);
        tbl[7]  = mk(0, 1, 8'h93, 1, 0, 0, 32'h13,       1, 1, 0, 0);
        tbl[8]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h13,       1, 1, 0, 0);
        tbl[9]  = mk(0, 1, 8'h10, 1, 0, 0, 32'h13,       1, 1, 0, 0);
        tbl[10] = mk(0, 1, 8'h00, 0, 1, 1, 32'h00100093, 1, 1, 0, 0);
        tbl[11] = mk(0, 1, 8'h92, 1, 0, 1, 32'h00100093, 1, 1, 0, 0);
        tbl[12] = mk(0, 1, 8'h92, 0, 0, 1, 32'h00100093, 0, 0, 1, 0);
        tbl[13] = mk(0, 0, 8'h00, 0, 0, 1, 32'h00100093, 0, 0, 1, 0);
        wr_addr_q.delete(); wr_data_q.delete();
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].start; s_valid = tbl[i].valid; s_data = tbl[i].data;
            @(negedge clk);
            chk($sformatf("vector %0d", i), 64'(outs()),
                64'({tbl[i].ready, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                     tbl[i].core_rst, tbl[i].busy, tbl[i].done, tbl[i].err}));
        end
        start = 1'b0; s_valid = 1'b0;
        frame1(8'h92); build_exp();
        check_writes("table frame");

        // Bad checksum: writes still happen, then error.
        wr_addr_q.delete(); wr_data_q.delete();
        do_start();
        chk("restart from done", 64'({core_rst, done, busy, s_ready}), 64'(4'b1011));
        frame1(8'h00); build_exp();
        send_frame(0);
        check_status("bad csum", 1'b0, 1'b1, 1'b1);
        check_writes("bad csum");

        // Full-depth load with random data.
        wr_addr_q.delete(); wr_data_q.delete();
        frame_q.delete();
        frame_q.push_back(8'h00);
        x = 8'h00;
        for (int i = 0; i < 128; i++) begin
            frame_q.push_back(8'($urandom_range(0, 255)));
            x = x ^ frame_q[i+1];
        end
        frame_q.push_back(x);
        build_exp();
        do_start();
        send_frame(0);
        check_status("full depth", 1'b1, 1'b0, 1'b0);
        check_writes("full depth");

        // Oversized length byte.
        wr_addr_q.delete(); wr_data_q.delete();
        do_start();
        send_byte(8'h21, 0);
        check_status("len 0x21", 1'b0, 1'b1, 1'b1);
        chk("len 0x21 no write", 64'(wr_addr_q.size()), 64'd0);
        do_start();
        chk("restart from error clears err", 64'({err, busy}), 64'(2'b01));
        frame1(8'h92); build_exp();
        send_frame(0);
        check_status("after len err", 1'b1, 1'b0, 1'b0);
        check_writes("after len err");

        // Gapped valid.
        wr_addr_q.delete(); wr_data_q.delete();
        ready_in_write = 0;
        do_start();
        send_frame(3);
        check_status("gapped", 1'b1, 1'b0, 1'b0);
        check_writes("gapped");
        chk("gapped ready during write", 64'(ready_in_write), 64'd0);

        // Asynchronous reset in the middle of word 1.
        do_start();
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0);
        s_valid = 1'b1; s_data = 8'h00;
        #2 rst = 1'b1;
        #1;
        chk("async reset mid-load", 64'(outs()), 64'(RESET_OUTS));
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        wr_addr_q.delete(); wr_data_q.delete();
        @(negedge clk);
        chk("idle after reset", 64'(outs()), 64'(RESET_OUTS));
        do_start();
        send_frame(0);
        check_status("after reset", 1'b1, 1'b0, 1'b0);
        check_writes("after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader directly upstream of the single-cycle core's instruction RAM.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words into the instruction RAM through its dataIN, address and readWrite inputs, and holds the core in reset until the load passes an XOR checksum.
- Frame format: length byte L, then 4*N data bytes, then one checksum byte. N = L, except that L = 0 means N = DEPTH.

Parameters:
- ADDR_W, 5, instruction RAM word-address width.
- DEPTH, 32, number of instruction RAM words. Must equal 2**ADDR_W.
- DATA_W, 32, instruction word width. Fixed at 4 bytes.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a load when idle, done or in error. Ignored while busy.
- s_valid  in  1  upstream byte valid.
- s_data  in  8  upstream byte.
- s_ready  out  1  loader can accept a byte. Registered.
- mem_we  out  1  instruction RAM write strobe. 1 = write, matching the RAM readWrite polarity.
- mem_addr  out  ADDR_W  instruction RAM word address.
- mem_wdata  out  DATA_W  instruction word to write.
- core_rst  out  1  reset to the core. Held 1 unless the last load succeeded.
- busy  out  1  a load is in progress.
- done  out  1  last load succeeded.
- err  out  1  last load failed (bad length or bad checksum).

Behaviour:
- Reset values (applied asynchronously): state IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, busy=0, done=0, err=0. Byte index, word index and checksum are all 0.
- Reset mid-load: the partial word is discarded and RAM contents are left untouched.
- A byte is accepted only in a cycle where s_valid && s_ready. s_data is sampled on that edge.
- s_valid may drop at any time. No byte is lost or duplicated.
- All outputs are registered.
- IDLE:
  - start=1 -> LEN.
  - Set busy=1, s_ready=1, done=0, err=0, core_rst=1.
- LEN: on accept of byte L:
  - L > DEPTH -> ERROR, with no RAM write.
  - Otherwise N = (L==0 ? DEPTH : L), checksum = L, word index = 0, -> COLLECT.
- COLLECT:
  - Accept 4 bytes. Byte k goes into bits [8k+7:8k].
  - checksum ^= byte on every accept.
  - On the 4th accept: s_ready=0, mem_wdata = assembled word, -> WRITE.
- WRITE: exactly one cycle with mem_we=1 and mem_addr = word index.
  - If word index == N-1 -> CHECK.
  - Otherwise word index + 1 -> COLLECT with s_ready=1.
  - mem_we is 0 in every other state.
  - mem_addr never wraps within a load. The last write goes to address N-1.
- CHECK: s_ready=1. On accept of byte C:
  - C == checksum -> DONE.
  - Otherwise -> ERROR.
- DONE: s_ready=0, busy=0, done=1, core_rst=0. Holds here.
  - start=1 -> LEN. core_rst returns to 1 and done to 0 on that same edge.
- ERROR: s_ready=0, busy=0, err=1, core_rst=1. Holds here.
  - start=1 -> LEN, clearing err.
- Latency:
  - The 4th byte of a word is accepted on edge k. mem_we=1 is visible after edge k and drops after edge k+1.
  - The checksum byte is accepted on edge j. done and core_rst change after edge j.
- Throughput: 5 cycles per word at best (4 accepts + 1 write cycle, during which s_ready=0).
- start asserted together with rst is ignored.
- start is level-sampled only in IDLE, DONE and ERROR.

Test Plan:
- Two-word load, continuous valid. Bytes 02, 13 00 00 00, 93 00 10 00, checksum 92 -> two writes: addr0=0x00000013, addr1=0x00100093. done=1, core_rst=0, err=0, exactly 2 mem_we pulses.
- Same frame with checksum 00 -> both writes occur, then err=1, done=0, core_rst stays 1.
- L=00, 128 random data bytes plus the correct XOR -> 32 writes, addresses 0..31 in order, no write to address 0 after 31, done=1.
- L=21 -> err=1 right after accept, no mem_we pulse, s_ready=0. A following start with a valid frame then succeeds.
- Two-word frame with s_valid randomly gapped -> identical writes and result to the first test. s_ready=0 in each WRITE cycle, no byte dropped.
- rst pulsed during the second data byte of word 1 -> all outputs return to reset values without waiting for a clock edge. A new start with a full frame loads correctly and ends with done=1.
